// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared bus command, arbiter state and tag definitions
//
// Purpose: types and constants shared by the memory-port arbiter, its
//          interface and anything else that talks to the D-memory bus.
// Contents:
//   MEM_TAG_W  width of the memory acceptance / return tag
//   bus_cmd_t  bus command (shared encoding with the memory bus)
//   arb_state_t arbiter FSM states
//   idx_width  index width for an N-entry requester vector
package mem_port_arbiter_pkg;

    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // A single requester still needs a 1-bit index field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - LSQ-side and memory-bus-side signal bundle of the port arbiter
//
// Purpose: groups the requester vectors, the memory bus command/return
//          signals and the per-requester response into one interface.
// Modports:
//   master  the arbiter: drives mem_cmd/mem_addr/mem_wdata, busy, cur_idx,
//           resp_valid, resp_data; samples flush, req*, mem_resp, mem_tag, mem_rdata
//   slave   the environment (LSQ + memory): the opposite directions
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int N      = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);

    localparam int IDX_W = idx_width(N);

    logic                             flush;
    logic [N-1:0]                     req;
    logic [N-1:0]                     req_we;
    logic [N-1:0][ADDR_W-1:0]         req_addr;
    logic [N-1:0][DATA_W-1:0]         req_wdata;

    bus_cmd_t                         mem_cmd;
    logic [ADDR_W-1:0]                mem_addr;
    logic [DATA_W-1:0]                mem_wdata;
    logic [MEM_TAG_W-1:0]             mem_resp;
    logic [MEM_TAG_W-1:0]             mem_tag;
    logic [DATA_W-1:0]                mem_rdata;

    logic                             busy;
    logic [IDX_W-1:0]                 cur_idx;
    logic [N-1:0]                     resp_valid;
    logic [DATA_W-1:0]                resp_data;

    modport master (
        input  flush, req, req_we, req_addr, req_wdata,
        input  mem_resp, mem_tag, mem_rdata,
        output mem_cmd, mem_addr, mem_wdata,
        output busy, cur_idx, resp_valid, resp_data
    );

    modport slave (
        output flush, req, req_we, req_addr, req_wdata,
        output mem_resp, mem_tag, mem_rdata,
        input  mem_cmd, mem_addr, mem_wdata,
        input  busy, cur_idx, resp_valid, resp_data
    );

endinterface

// File: rtl/mem_port_arbiter_pselect.sv
// rtl/mem_port_arbiter_pselect.sv - rotating priority select, binary index out, upward scan
//
// Module binary_pselect_dir0
// Purpose: returns the index of the first set bit of req found scanning
//          upward from sel and wrapping to 0. Purely combinational.
// Ports:
//   req    in  N      request vector
//   en     in  1      qualifies valid
//   sel    in  IDX_W  starting position of the scan (must be < N)
//   idx    out IDX_W  winning index (0 when nothing requests)
//   valid  out 1      en && |req
module binary_pselect_dir0 #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [IDX_W-1:0] sel,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_found;

    // Two candidates instead of a modulo scan: the lowest request at or
    // above sel, and the lowest request overall (the wrapped case). The
    // downward loop leaves the lowest matching index in each.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= sel) begin
                    hi_idx   = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign idx   = hi_found ? hi_idx : lo_idx;
    assign valid = en && (|req);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - rotating-priority sharing of the single D-memory port among LSQ slots
//
// Purpose: picks one of N load/store requesters, drives its command on the
//          memory bus until accepted, waits for tagged load data, then pulses
//          a one-cycle response to the winner. At most one request is ever
//          outstanding at the memory.
// Ports:
//   clock      in   1        rising-edge clock
//   reset      in   1        asynchronous, active-low
//   bus        master modport of mem_port_arbiter_if:
//     flush                  abort current transaction, block new grants
//     req/req_we/req_addr/req_wdata   per-requester command
//     mem_cmd/mem_addr/mem_wdata      bus command (registered fields)
//     mem_resp   acceptance tag, 0 = rejected;  mem_tag/mem_rdata load return
//     busy       FSM not idle;  cur_idx  owner of the port while busy
//     resp_valid one-hot completion pulse;  resp_data  load data (0 for stores)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N      = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);

    localparam int               IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
    logic                 lat_we_q, lat_we_d;
    logic [ADDR_W-1:0]    lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]    lat_wdata_q, lat_wdata_d;
    logic [MEM_TAG_W-1:0] tag_q, tag_d;
    logic                 drop_q, drop_d;
    logic [N-1:0]         resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]    resp_data_q, resp_data_d;

    logic [IDX_W-1:0]     win_idx;
    logic                 win_valid;
    logic [IDX_W-1:0]     ptr_after;
    logic                 tag_hit;

    binary_pselect_dir0 #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pselect (
        .req   (bus.req),
        .en    (state_q == IDLE),
        .sel   (ptr_q),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Explicit wrap so a non-power-of-two N never lands on an unused index.
    assign ptr_after = (cur_idx_q == LAST_IDX) ? '0 : cur_idx_q + 1'b1;
    assign tag_hit   = (bus.mem_tag == tag_q) && (tag_q != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cur_idx_q    <= '0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            tag_q        <= '0;
            drop_q       <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_idx_q    <= cur_idx_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            tag_q        <= tag_d;
            drop_q       <= drop_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_idx_d    = cur_idx_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        tag_d        = tag_q;
        drop_d       = drop_q;
        resp_valid_d = '0;
        resp_data_d  = '0;

        case (state_q)
            IDLE: begin
                if (win_valid && !bus.flush) begin
                    cur_idx_d   = win_idx;
                    lat_we_d    = bus.req_we[win_idx];
                    lat_addr_d  = bus.req_addr[win_idx];
                    lat_wdata_d = bus.req_wdata[win_idx];
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                // Flush masks the command this cycle, so memory never saw
                // it and there is nothing to wait for.
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.mem_resp != '0) begin
                    if (lat_we_q) begin
                        state_d                 = IDLE;
                        resp_valid_d[cur_idx_q] = 1'b1;
                        ptr_d                   = ptr_after;
                    end else begin
                        tag_d   = bus.mem_resp;
                        drop_d  = 1'b0;
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                // Memory cannot cancel a load, so a flushed load still waits
                // for its tag to keep the return stream in order.
                if (tag_hit) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !bus.flush) begin
                        resp_valid_d[cur_idx_q] = 1'b1;
                        resp_data_d             = bus.mem_rdata;
                        ptr_d                   = ptr_after;
                    end
                end else if (bus.flush) begin
                    drop_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_cmd    = (state_q == ISSUE && !bus.flush)
                            ? (lat_we_q ? BUS_STORE : BUS_LOAD) : BUS_NONE;
    assign bus.mem_addr   = lat_addr_q;
    assign bus.mem_wdata  = lat_wdata_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.cur_idx    = cur_idx_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N      = 6;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;

    logic [N-1:0]        we_v;
    logic [ADDR_W-1:0]   addr_v  [N];
    logic [DATA_W-1:0]   wdata_v [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_winner(input logic [N-1:0] mask, input int p);
        for (int k = 0; k < N; k++)
            if (mask[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive_req_fields();
        bus.req_we = we_v;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i]  = addr_v[i];
            bus.req_wdata[i] = wdata_v[i];
        end
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            we_v[i]    = 1'($urandom);
            addr_v[i]  = $urandom;
            wdata_v[i] = {$urandom, $urandom};
        end
    endtask

    // One transaction from an idle port. fmode: 0 none, 1 flush in ISSUE,
    // 2 flush in first WAIT cycle, 3 flush together with the tag return.
    task automatic do_txn(input logic [N-1:0] mask, input int nrej, input int lat, input int fmode,
                          input logic [3:0] tag, input logic [63:0] rdata, input bit pre_flush);
        int       w;
        bus_cmd_t exp_cmd;
        bit       dropped;
        w       = exp_winner(mask, ptr_m);
        exp_cmd = we_v[w] ? BUS_STORE : BUS_LOAD;
        drive_req_fields();
        bus.req      = mask;
        bus.mem_resp = 4'($urandom);
        bus.mem_tag  = 4'($urandom);
        if (pre_flush) begin
            bus.flush = 1'b1;
            tick();
            check("flush_blocks_grant", 64'(bus.busy), 64'd0);
            bus.flush = 1'b0;
        end
        tick();
        check("grant_busy", 64'(bus.busy), 64'd1);
        check("grant_idx", 64'(bus.cur_idx), 64'(w));
        if (fmode == 1) begin
            bus.flush    = 1'b1;
            bus.mem_resp = tag;
            bus.req      = '0;
            #1;
            check("flush_issue_cmd", 64'(bus.mem_cmd), 64'(BUS_NONE));
            tick();
            bus.flush    = 1'b0;
            bus.mem_resp = '0;
            check("flush_issue_idle", 64'(bus.busy), 64'd0);
            check("flush_issue_noresp", 64'(bus.resp_valid), 64'd0);
            return;
        end
        for (int r = 0; r < nrej; r++) begin
            bus.mem_resp = '0;
            bus.mem_tag  = 4'($urandom);
            #1;
            check("retry_cmd", 64'(bus.mem_cmd), 64'(exp_cmd));
            check("retry_addr", 64'(bus.mem_addr), 64'(addr_v[w]));
            check("retry_wdata", 64'(bus.mem_wdata), 64'(wdata_v[w]));
            tick();
            check("retry_busy", 64'(bus.busy), 64'd1);
            check("retry_noresp", 64'(bus.resp_valid), 64'd0);
        end
        bus.mem_resp = tag;
        bus.mem_tag  = '0;
        #1;
        check("issue_cmd", 64'(bus.mem_cmd), 64'(exp_cmd));
        check("issue_addr", 64'(bus.mem_addr), 64'(addr_v[w]));
        check("issue_wdata", 64'(bus.mem_wdata), 64'(wdata_v[w]));
        bus.req = '0;
        tick();
        bus.mem_resp = '0;
        if (we_v[w]) begin
            check("store_idle", 64'(bus.busy), 64'd0);
            check("store_resp", 64'(bus.resp_valid), 64'd1 << w);
            check("store_data", 64'(bus.resp_data), 64'd0);
            ptr_m = (w + 1) % N;
        end else begin
            for (int l = 0; l < lat; l++) begin
                bus.mem_tag = tag ^ 4'($urandom_range(1, 15));
                bus.flush   = (fmode == 2 && l == 0);
                #1;
                check("wait_cmd", 64'(bus.mem_cmd), 64'(BUS_NONE));
                tick();
                bus.flush = 1'b0;
                check("wait_busy", 64'(bus.busy), 64'd1);
                check("wait_noresp", 64'(bus.resp_valid), 64'd0);
            end
            dropped       = (fmode == 2 && lat > 0) || (fmode == 3);
            bus.mem_tag   = tag;
            bus.mem_rdata = rdata;
            bus.flush     = (fmode == 3);
            #1;
            check("wait_cmd_tag", 64'(bus.mem_cmd), 64'(BUS_NONE));
            tick();
            bus.flush   = 1'b0;
            bus.mem_tag = '0;
            check("load_idle", 64'(bus.busy), 64'd0);
            if (dropped) begin
                check("load_dropped", 64'(bus.resp_valid), 64'd0);
            end else begin
                check("load_resp", 64'(bus.resp_valid), 64'd1 << w);
                check("load_data", 64'(bus.resp_data), rdata);
                ptr_m = (w + 1) % N;
            end
        end
        tick();
        check("resp_one_cycle", 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_idx"}, 64'(bus.cur_idx), 64'd0);
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_resp_data"}, 64'(bus.resp_data), 64'd0);
        check({tag, "_cmd"}, 64'(bus.mem_cmd), 64'(BUS_NONE));
        check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.flush     = 1'b0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_resp  = '0;
        bus.mem_tag   = '0;
        bus.mem_rdata = '0;
        randomize_fields();

        // Reset values
        #12;
        check_reset_values("reset");
        tick();
        reset = 1'b1;
        tick();

        // Single load: requester 2, addr 0x100, accept tag 3, tag back two cycles later
        we_v       = '0;
        addr_v[2]  = 32'h100;
        do_txn(6'h04, 0, 1, 0, 4'd3, 64'hDEAD, 1'b0);

        // Reject/retry: store rejected 3 times then accepted with tag 5
        we_v = '1;
        do_txn(6'h10, 3, 0, 0, 4'd5, 64'd0, 1'b0);

        // Flush in WAIT: load, tag 2, flush pulse, later tag 2, then a normal grant
        we_v = '0;
        do_txn(6'h02, 0, 2, 2, 4'd2, 64'h1234, 1'b0);
        do_txn(6'h02, 0, 1, 0, 4'd2, 64'h5678, 1'b0);

        // Wrap: drive ptr to N-1, then both ends request
        we_v = '1;
        do_txn(6'b010000, 0, 0, 0, 4'd1, 64'd0, 1'b0);
        do_txn(6'b100001, 0, 0, 0, 4'd1, 64'd0, 1'b0);
        do_txn(6'b100001, 0, 0, 0, 4'd1, 64'd0, 1'b0);

        // Rotation: all requesters store continuously, memory always accepts
        randomize_fields();
        we_v = '1;
        drive_req_fields();
        bus.req      = '1;
        bus.mem_resp = 4'd1;
        for (int g = 0; g < 2 * N + 1; g++) begin
            int w;
            w = exp_winner('1, ptr_m);
            tick();
            check("rot_idx", 64'(bus.cur_idx), 64'(w));
            check("rot_cmd", 64'(bus.mem_cmd), 64'(BUS_STORE));
            check("rot_addr", 64'(bus.mem_addr), 64'(addr_v[w]));
            tick();
            check("rot_idle", 64'(bus.busy), 64'd0);
            check("rot_resp", 64'(bus.resp_valid), 64'd1 << w);
            ptr_m = (w + 1) % N;
        end
        bus.req      = '0;
        bus.mem_resp = '0;
        tick();
        check("rot_end_idle", 64'(bus.busy), 64'd0);
        check("rot_end_noresp", 64'(bus.resp_valid), 64'd0);

        // Reset in WAIT, then a stale tag return
        we_v = '0;
        drive_req_fields();
        bus.req = 6'h08;
        tick();
        bus.req      = '0;
        bus.mem_resp = 4'd7;
        tick();
        bus.mem_resp = '0;
        check("pre_reset_wait", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        reset = 1'b1;
        ptr_m = 0;
        bus.mem_tag   = 4'd7;
        bus.mem_rdata = 64'hBAD;
        tick();
        check("stale_tag_noresp", 64'(bus.resp_valid), 64'd0);
        check("stale_tag_idle", 64'(bus.busy), 64'd0);
        bus.mem_tag = '0;
        tick();
        check("stale_tag_noresp2", 64'(bus.resp_valid), 64'd0);

        // Randomized transactions
        for (int t = 0; t < 150; t++) begin
            int fm;
            randomize_fields();
            fm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), fm, 4'($urandom_range(1, 15)),
                   {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
